// File: rtl/seg7_pattern_decoder.sv
// Recovers a hex digit from a 7-bit active-low segment bus once the pattern has been
// stable for STABLE_CYCLES samples; keeps a 4-digit history and a saturating error count.
module seg7_pattern_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg_in,
    output logic [3:0]  digit,
    output logic        digit_valid,
    output logic        err,
    output logic [15:0] history,
    output logic [7:0]  err_count
);

    typedef enum logic {
        HOLD  = 1'b0,
        COUNT = 1'b1
    } state_t;

    localparam logic [6:0]       BLANK      = 7'h7F;
    localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(STABLE_CYCLES);

    // Returns {legal, code}; legal is 0 for anything outside the hex glyph set.
    function automatic logic [4:0] decode_seg(input logic [6:0] p);
        case (p)
            7'b0000001: decode_seg = {1'b1, 4'h0};
            7'b1001111: decode_seg = {1'b1, 4'h1};
            7'b0010010: decode_seg = {1'b1, 4'h2};
            7'b0000110: decode_seg = {1'b1, 4'h3};
            7'b1001100: decode_seg = {1'b1, 4'h4};
            7'b0100100: decode_seg = {1'b1, 4'h5};
            7'b0100000: decode_seg = {1'b1, 4'h6};
            7'b0001111: decode_seg = {1'b1, 4'h7};
            7'b0000000: decode_seg = {1'b1, 4'h8};
            7'b0000100: decode_seg = {1'b1, 4'h9};
            7'b0001000: decode_seg = {1'b1, 4'hA};
            7'b1100000: decode_seg = {1'b1, 4'hB};
            7'b0110001: decode_seg = {1'b1, 4'hC};
            7'b1000010: decode_seg = {1'b1, 4'hD};
            7'b0110000: decode_seg = {1'b1, 4'hE};
            7'b0111000: decode_seg = {1'b1, 4'hF};
            default:    decode_seg = 5'b0_0000;
        endcase
    endfunction

    logic [6:0]       s1_q, s1_d;
    logic [6:0]       cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_t           state_q, state_d;
    logic [3:0]       digit_q, digit_d;
    logic             digit_valid_q, digit_valid_d;
    logic             err_q, err_d;
    logic [15:0]      history_q, history_d;
    logic [7:0]       err_count_q, err_count_d;

    logic [CNT_W-1:0] cnt_inc_s;
    logic             accept_s;
    logic [4:0]       dec_s;

    // Qualification FSM and acceptance side effects.
    always_comb begin
        s1_d          = seg_in;
        cand_d        = cand_q;
        cnt_d         = cnt_q;
        state_d       = state_q;
        digit_d       = digit_q;
        digit_valid_d = 1'b0;
        err_d         = 1'b0;
        history_d     = history_q;
        err_count_d   = err_count_q;
        accept_s      = 1'b0;
        cnt_inc_s     = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        dec_s         = decode_seg(cand_q);

        // Any change at s1 restarts qualification, even mid-count.
        if (s1_q != cand_q) begin
            cand_d  = s1_q;
            cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
            state_d = COUNT;
        end else begin
            case (state_q)
                COUNT: begin
                    cnt_d = cnt_inc_s;
                    if (cnt_inc_s == CNT_TARGET) begin
                        accept_s = 1'b1;
                        state_d  = HOLD;
                    end else begin
                        accept_s = 1'b0;
                    end
                end
                HOLD: begin
                    state_d = HOLD;
                end
                default: begin
                    state_d = HOLD;
                end
            endcase
        end

        if (accept_s) begin
            if (dec_s[4]) begin
                digit_d       = dec_s[3:0];
                history_d     = {history_q[11:0], dec_s[3:0]};
                digit_valid_d = 1'b1;
            end else if (cand_q == BLANK) begin
                digit_valid_d = 1'b0;
            end else begin
                err_d = 1'b1;
                if (err_count_q != 8'hFF) begin
                    err_count_d = err_count_q + 8'd1;
                end else begin
                    err_count_d = err_count_q;
                end
            end
        end else begin
            digit_valid_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q          <= 7'h7F;
            cand_q        <= 7'h7F;
            cnt_q         <= {CNT_W{1'b0}};
            state_q       <= HOLD;
            digit_q       <= 4'h0;
            digit_valid_q <= 1'b0;
            err_q         <= 1'b0;
            history_q     <= 16'h0000;
            err_count_q   <= 8'h00;
        end else begin
            s1_q          <= s1_d;
            cand_q        <= cand_d;
            cnt_q         <= cnt_d;
            state_q       <= state_d;
            digit_q       <= digit_d;
            digit_valid_q <= digit_valid_d;
            err_q         <= err_d;
            history_q     <= history_d;
            err_count_q   <= err_count_d;
        end
    end

    assign digit       = digit_q;
    assign digit_valid = digit_valid_q;
    assign err         = err_q;
    assign history     = history_q;
    assign err_count   = err_count_q;

endmodule

// File: tb/tb_seg7_pattern_decoder.sv
// Scoreboard bench: stimulus is a list of constant runs on seg_in; a run-length model
// predicts each pulse and its cycle, and a monitor pops and compares on every pulse.
module tb_seg7_pattern_decoder;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg_in = 7'h7F;
    logic [3:0]  digit;
    logic        digit_valid;
    logic        err;
    logic [15:0] history;
    logic [7:0]  err_count;

    seg7_pattern_decoder #(.STABLE_CYCLES(S), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .digit(digit),
        .digit_valid(digit_valid), .err(err), .history(history), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        bit          is_err;
        logic [3:0]  digit;
        logic [15:0] hist;
        logic [7:0]  errc;
    } ev_t;

    ev_t sb_q[$];
    int  cyc = 0;
    int  total = 0;
    int  bad = 0;
    int  dv_count = 0;
    int  err_pulses = 0;

    logic [6:0] tbl [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                             7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                             7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                             7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    // model state
    logic [3:0]  m_digit = 4'h0;
    logic [15:0] m_hist = 16'h0;
    logic [7:0]  m_errc = 8'h0;
    logic [6:0]  cur_pat = 7'h7F;
    int          run_start = 0;
    int          run_len = 0;
    bit          run_done = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int dec(input logic [6:0] p);
        for (int i = 0; i < 16; i++) if (tbl[i] == p) return i;
        return -1;
    endfunction

    task automatic model_accept(input logic [6:0] p, input int at);
        int  d;
        ev_t e;
        if (p == 7'h7F) return;
        d = dec(p);
        if (d >= 0) begin
            m_digit  = d[3:0];
            m_hist   = {m_hist[11:0], d[3:0]};
            e.is_err = 1'b0;
        end else begin
            e.is_err = 1'b1;
            if (m_errc != 8'd255) m_errc = m_errc + 8'd1;
        end
        e.cyc = at; e.digit = m_digit; e.hist = m_hist; e.errc = m_errc;
        sb_q.push_back(e);
    endtask

    // Called at a falling edge; drives p for len clock edges.
    task automatic drive_run(input logic [6:0] p, input int len);
        if (p != cur_pat) begin
            cur_pat   = p;
            run_start = cyc + 1;
            run_len   = 0;
            run_done  = 1'b0;
        end
        run_len += len;
        if (!run_done && run_len >= S) begin
            run_done = 1'b1;
            model_accept(p, run_start + S);
        end
        seg_in = p;
        repeat (len) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        #1 rst_n = 1'b0;
        sb_q.delete();
        m_digit = 4'h0; m_hist = 16'h0; m_errc = 8'h0;
        cur_pat = 7'h7F; run_len = 0; run_done = 1'b1;
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: pops the scoreboard on every pulse and flags missed/extra pulses.
    always @(negedge clk) begin
        ev_t e;
        if (!rst_n) begin
            check("reset_outputs", {digit, digit_valid, err, history, err_count}, 32'h0);
        end else begin
            if (digit_valid && err) check("pulse_exclusive", 32'h1, 32'h0);
            if (digit_valid || err) begin
                if (digit_valid) dv_count++;
                if (err) err_pulses++;
                if (sb_q.size() == 0) begin
                    check("unexpected_pulse", {30'h0, digit_valid, err}, 32'h0);
                end else begin
                    e = sb_q.pop_front();
                    check("pulse_cycle", cyc, e.cyc);
                    check("pulse_kind", {31'h0, err}, {31'h0, e.is_err});
                    check("digit", {28'h0, digit}, {28'h0, e.digit});
                    check("history", {16'h0, history}, {16'h0, e.hist});
                    check("err_count", {24'h0, err_count}, {24'h0, e.errc});
                end
            end else if (sb_q.size() != 0 && sb_q[0].cyc < cyc) begin
                e = sb_q.pop_front();
                check("missed_pulse", 32'h0, e.cyc);
            end
        end
    end

    initial begin
        int k;
        logic [6:0] p;

        // 1: reset with blank then idle
        do_reset(3);
        drive_run(7'h7F, 20);
        check("idle_outputs", {digit, digit_valid, err, history, err_count}, 32'h0);
        check("idle_no_pulse", dv_count + err_pulses, 0);

        // 2: single digit 2, held long
        dv_count = 0;
        drive_run(7'b0010010, 12);
        check("d2_pulses", dv_count, 1);
        check("d2_digit", {28'h0, digit}, 32'h2);
        check("d2_history", {16'h0, history}, 32'h0002);

        // 3: digit sequence separated by blanks
        do_reset(2);
        dv_count = 0;
        drive_run(7'b0010010, 6); drive_run(7'h7F, 6);
        drive_run(7'b0111000, 6); drive_run(7'h7F, 6);
        drive_run(7'b1100000, 6); drive_run(7'h7F, 6);
        drive_run(7'b0000001, 6); drive_run(7'h7F, 6);
        drive_run(7'b1001111, 6); drive_run(7'h7F, 6);
        check("seq_pulses", dv_count, 5);
        check("seq_history", {16'h0, history}, 32'hFB01);
        check("seq_digit", {28'h0, digit}, 32'h1);

        // 4: glitch of 3 cycles then a held digit
        dv_count = 0;
        drive_run(7'b0000001, 3);
        drive_run(7'b1001111, 8);
        check("glitch_pulses", dv_count, 1);
        check("glitch_digit", {28'h0, digit}, 32'h1);

        // 5: illegal pattern repeated until the error counter saturates
        dv_count = 0; err_pulses = 0;
        for (int i = 0; i < 300; i++) begin
            drive_run(7'b1111110, 5);
            drive_run(7'h7F, 5);
        end
        check("sat_err_pulses", err_pulses, 300);
        check("sat_dv_pulses", dv_count, 0);
        check("sat_err_count", {24'h0, err_count}, 32'd255);

        // 6: reset during qualification
        drive_run(7'b0000110, 2);
        do_reset(3);
        dv_count = 0;
        drive_run(7'b0000110, 8);
        check("rst_pulses", dv_count, 1);
        check("rst_digit", {28'h0, digit}, 32'h3);
        check("rst_history", {16'h0, history}, 32'h0003);
        check("rst_err_count", {24'h0, err_count}, 32'h0);

        // 7: random runs of legal, blank and arbitrary patterns
        do_reset(2);
        for (int i = 0; i < 250; i++) begin
            k = $urandom_range(0, 9);
            if (k < 6) p = tbl[$urandom_range(0, 15)];
            else if (k < 8) p = 7'h7F;
            else p = 7'($urandom_range(0, 127));
            drive_run(p, $urandom_range(1, 7));
        end
        drive_run(7'h7F, 12);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
